// File: rtl/vector_recorder_pkg.sv
// -----------------------------------------------------------------------------
// vector_recorder_pkg
// Shared types and constants for the vector recorder.
//   - state_e     : recorder FSM states (IDLE, CAPTURE, DRAIN)
//   - VR_VW       : default vector width
//   - VR_DEPTH    : default buffer depth (power of 2, >= 2)
//   - vr_ptr_w()  : pointer width for a given depth
//   - VR_PTR_W    : pointer width for the default depth
// -----------------------------------------------------------------------------
package vector_recorder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    localparam int VR_VW    = 4;
    localparam int VR_DEPTH = 16;

    // Address width needed to index DEPTH entries; never below one bit.
    function automatic int vr_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int VR_PTR_W = vr_ptr_w(VR_DEPTH);

endpackage : vector_recorder_pkg

// File: rtl/vr_mem.sv
// -----------------------------------------------------------------------------
// vr_mem
// One-write / one-read register array holding the recorded vectors.
// Contents are not reset; write is synchronous, read is combinational.
// Ports:
//   clk      in   clock
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr    in   read address
//   rdata    out  read data (mem[raddr], combinational)
// -----------------------------------------------------------------------------
module vr_mem
    import vector_recorder_pkg::*;
#(
    parameter int VW    = VR_VW,
    parameter int DEPTH = VR_DEPTH,
    parameter int AW    = vr_ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [VW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [VW-1:0] rdata
);

    logic [VW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : vr_mem

// File: rtl/vector_recorder.sv
// -----------------------------------------------------------------------------
// vector_recorder
// Records qualified DUT vectors into a buffer, then plays them back over a
// valid/ready stream with a last-word marker.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   arm        in   start a new capture (IDLE only)
//   stop       in   end capture and begin playback (CAPTURE only)
//   sample_en  in   qualifies vec_in this cycle
//   vec_in     in   vector to record
//   rd_valid   out  playback word available
//   rd_ready   in   consumer accepts word
//   rd_data    out  playback word (0 when rd_valid is low)
//   rd_last    out  final playback word marker
//   count      out  entries captured in current/last run (saturates at DEPTH)
//   overflow   out  sticky: a sample was dropped on a full buffer
//   done       out  one-cycle pulse when playback completes
// -----------------------------------------------------------------------------
module vector_recorder
    import vector_recorder_pkg::*;
#(
    parameter int VW    = VR_VW,
    parameter int DEPTH = VR_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   sample_en,
    input  logic [VW-1:0]          vec_in,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [VW-1:0]          rd_data,
    output logic                   rd_last,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   done
);

    localparam int              PTR_W   = vr_ptr_w(DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  ONE_C   = (PTR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;

    logic                full;
    logic                wr_en;
    logic [PTR_W:0]      count_after_wr;
    logic                is_last;
    logic                handshake;
    logic [VW-1:0]       mem_rdata;

    // While count < DEPTH its low bits are exactly the next free slot.
    assign full           = (count_q == DEPTH_C);
    assign wr_en          = (state_q == ST_CAPTURE) && sample_en && !full;
    assign count_after_wr = count_q + {{PTR_W{1'b0}}, wr_en};
    assign is_last        = ({1'b0, rd_ptr_q} == (count_q - ONE_C));
    assign handshake      = rd_valid && rd_ready;

    vr_mem #(
        .VW    (VW),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (count_q[PTR_W-1:0]),
        .wdata (vec_in),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d    = ST_CAPTURE;
                    count_d    = '0;
                    rd_ptr_d   = '0;
                    overflow_d = 1'b0;
                end
            end

            ST_CAPTURE: begin
                count_d = count_after_wr;
                if (sample_en && full) begin
                    overflow_d = 1'b1;
                end
                // A sample in the same cycle as stop is already included
                // in count_after_wr, so it decides drain vs. empty.
                if (stop) begin
                    rd_ptr_d = '0;
                    if (count_after_wr != '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                if (handshake) begin
                    if (is_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // Outputs derive from registered state only, so an asynchronous reset
    // clears them at once without waiting for a clock edge.
    assign rd_valid = (state_q == ST_DRAIN);
    assign rd_data  = rd_valid ? mem_rdata : '0;
    assign rd_last  = rd_valid && is_last;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule : vector_recorder
